// File: rtl/checksum_engine_pkg.sv
// Shared types and the end-around-carry adder for the checksum engine.
// Pure declarations: no latency, no flow control.
// ones_add works on any checksum width up to CSUM_MAX_W bits.
package checksum_engine_pkg;

  localparam int CSUM_MAX_W = 64;

  typedef enum logic {
    GENERATE = 1'b0,
    CHECK    = 1'b1
  } checksum_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ones'-complement add of two w-bit values. The carry out of bit w-1 is
  // wrapped back into bit 0; the wrap itself can never carry again.
  function automatic logic [CSUM_MAX_W-1:0] ones_add(
    input logic [CSUM_MAX_W-1:0] a,
    input logic [CSUM_MAX_W-1:0] b,
    input logic [6:0]            w
  );
    logic [CSUM_MAX_W:0] sum;
    logic [CSUM_MAX_W:0] mask;
    logic [CSUM_MAX_W:0] cin;
    sum  = {1'b0, a} + {1'b0, b};
    mask = ((CSUM_MAX_W+1)'(1) << w) - (CSUM_MAX_W+1)'(1);
    cin  = (CSUM_MAX_W+1)'(sum[w]);
    sum  = (sum & mask) + cin;
    return sum[CSUM_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/checksum_engine_fold_comb.sv
// Folds WORDS_PER_CYCLE checksum words into the running ones'-complement sum.
// Latency: purely combinational.
// Backpressure: none; the caller decides when acc_o is captured.
module checksum_engine_fold_comb
  import checksum_engine_pkg::*;
#(
  parameter int CSUM_W          = 8,
  parameter int WORDS_PER_CYCLE = 2
) (
  input  logic [CSUM_W-1:0]                 acc_i,
  input  logic [WORDS_PER_CYCLE*CSUM_W-1:0] words_i,
  output logic [CSUM_W-1:0]                 acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < WORDS_PER_CYCLE; i++) begin
      acc_o = CSUM_W'(ones_add(CSUM_MAX_W'(acc_o),
                               CSUM_MAX_W'(words_i[i*CSUM_W +: CSUM_W]),
                               7'(CSUM_W)));
    end
  end

endmodule

// File: rtl/checksum_engine.sv
// Ones'-complement checksum generate/check engine; optional CHECKSUM_ERR_CNT_EN adds err_cnt_o.
// Latency: NCYC+1 cycles from accept to out_valid, NCYC = ceil(NWORDS/WORDS_PER_CYCLE).
// Backpressure: result held in DONE until out_ready; a new flit is taken in the same cycle.
module checksum_engine
  import checksum_engine_pkg::*;
#(
  parameter int DATA_W          = 64,
  parameter int CSUM_W          = 8,
  parameter int WORDS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CSUM_W-1:0] csum_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_o,
  output logic [CSUM_W-1:0] csum_o,
  output logic              is_valid_o,
  output logic              busy_o
`ifdef CHECKSUM_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam int NWORDS  = (DATA_W + CSUM_W - 1) / CSUM_W;
  localparam int NCYC    = (NWORDS + WORDS_PER_CYCLE - 1) / WORDS_PER_CYCLE;
  localparam int SLICE_W = WORDS_PER_CYCLE * CSUM_W;
  localparam int PAD_W   = NCYC * SLICE_W;
  localparam int CNT_W   = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_t             state_q;
  checksum_mode_t     mode_q;
  logic [CSUM_W-1:0]  acc_q;
  logic [CSUM_W-1:0]  acc_fold;
  logic [CSUM_W-1:0]  csum_next;
  logic [CSUM_W-1:0]  csum_in_q;
  logic [CSUM_W-1:0]  csum_q;
  logic [PAD_W-1:0]   work_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cyc_q;
  logic               is_valid_q;
  logic               accept;
  logic               last_cyc;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == ST_DONE);
  assign busy_o     = (state_q != ST_IDLE);
  assign data_o     = data_q;
  assign csum_o     = csum_q;
  assign is_valid_o = is_valid_q;
  assign last_cyc   = (cyc_q == CNT_W'(NCYC - 1));
  assign csum_next  = ~acc_fold;

  // The working copy is zero-padded to a whole number of slices, so the
  // words past NWORDS in the last CALC cycle add zero.
  checksum_engine_fold_comb #(
    .CSUM_W          (CSUM_W),
    .WORDS_PER_CYCLE (WORDS_PER_CYCLE)
  ) u_fold (
    .acc_i   (acc_q),
    .words_i (work_q[SLICE_W-1:0]),
    .acc_o   (acc_fold)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= GENERATE;
      acc_q      <= '0;
      csum_in_q  <= '0;
      csum_q     <= '0;
      work_q     <= '0;
      data_q     <= '0;
      cyc_q      <= '0;
      is_valid_q <= 1'b0;
    end else if (accept) begin
      state_q   <= ST_CALC;
      mode_q    <= checksum_mode_t'(mode_i);
      acc_q     <= '0;
      csum_in_q <= csum_i;
      work_q    <= PAD_W'(data_i);
      data_q    <= data_i;
      cyc_q     <= '0;
    end else begin
      case (state_q)
        ST_CALC: begin
          acc_q  <= acc_fold;
          work_q <= work_q >> SLICE_W;
          cyc_q  <= cyc_q + CNT_W'(1);
          if (last_cyc) begin
            state_q    <= ST_DONE;
            csum_q     <= csum_next;
            is_valid_q <= (mode_q == CHECK) ? (csum_in_q == csum_next) : 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

`ifdef CHECKSUM_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  assign err_cnt_o = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && (mode_q == CHECK) && !is_valid_q &&
                 (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`endif

endmodule
